multi_ctrl_fsm: RTL and testbench

Sequencing controller for the multicycle ARM datapath. Sequences fetch, decode, execute, memory and writeback steps through a Moore main FSM, decodes the ALU command, and gates all architectural write enables with the condition-check result. Also counts retired instructions. Sits between the instruction register / condition logic and the shared-memory datapath.

---
 rtl/multi_ctrl_fsm.sv | 192 +++++++++++++++++++
 tb/tb_multi_ctrl_fsm.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_ctrl_fsm.sv
// Multicycle ARM sequencing controller: Moore main FSM, ALU command decode,
// condition-gated architectural write enables and a retired-instruction counter.
module multi_ctrl_fsm (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  op,
   input  logic [5:0]  funct,
   input  logic [3:0]  rd,
   input  logic        cond_ex,
   output logic        ir_write,
   output logic        adr_src,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  result_src,
   output logic [1:0]  alu_control,
   output logic        pc_write,
   output logic        reg_write,
   output logic        mem_write,
   output logic [1:0]  flag_write,
   output logic        illegal_instr,
   output logic [3:0]  state_dbg,
   output logic [31:0] instret
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_UNKNOWN  = 4'd10
   } state_t;

   state_t      state;
   state_t      state_nx;
   state_t      dec_state;

   logic        ir_w;
   logic        next_pc;
   logic        reg_w;
   logic        mem_w;
   logic        alu_op;
   logic        branch;
   logic [3:0]  cmd;
   logic [1:0]  flag_w;
   logic        no_write_dec;
   logic        no_write_q;
   logic        no_write_eff;
   logic        rd_pc;
   logic        retire;

   // State register, retirement counter and the no_write latch for ALUWB
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= S_FETCH;
         instret    <= '0;
         no_write_q <= 1'b0;
      end else begin
         state <= state_nx;
         if (retire)
            instret <= instret + 32'd1;
         if (state == S_EXECUTER || state == S_EXECUTEI)
            no_write_q <= no_write_dec;
      end
   end

   always_comb begin
      state_nx   = S_FETCH;
      ir_w       = 1'b0;
      next_pc    = 1'b0;
      adr_src    = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      result_src = 2'b00;
      reg_w      = 1'b0;
      mem_w      = 1'b0;
      alu_op     = 1'b0;
      branch     = 1'b0;

      case (state)
         S_FETCH:  state_nx = S_DECODE;
         S_DECODE: begin
            case (op)
               2'b01:   state_nx = S_MEMADR;
               2'b00:   state_nx = funct[5] ? S_EXECUTEI : S_EXECUTER;
               2'b10:   state_nx = S_BRANCH;
               default: state_nx = S_UNKNOWN;
            endcase
         end
         S_MEMADR:   state_nx = funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:    state_nx = S_MEMWB;
         S_EXECUTER: state_nx = S_ALUWB;
         S_EXECUTEI: state_nx = S_ALUWB;
         default:    state_nx = S_FETCH;
      endcase

      // Held in reset the datapath sees the FETCH decode; enables are gated below
      dec_state = reset ? state : S_FETCH;

      case (dec_state)
         S_FETCH: begin
            ir_w       = 1'b1;
            next_pc    = 1'b1;
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
         end
         S_DECODE: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
         end
         S_MEMADR: alu_src_b = 2'b01;
         S_MEMRD:  adr_src = 1'b1;
         S_MEMWB: begin
            result_src = 2'b01;
            reg_w      = 1'b1;
         end
         S_MEMWR: begin
            adr_src = 1'b1;
            mem_w   = 1'b1;
         end
         S_EXECUTER: alu_op = 1'b1;
         S_EXECUTEI: begin
            alu_op    = 1'b1;
            alu_src_b = 2'b01;
         end
         S_ALUWB: reg_w = 1'b1;
         S_BRANCH: begin
            alu_src_b  = 2'b01;
            result_src = 2'b10;
            branch     = 1'b1;
         end
         default: ;
      endcase
   end

   assign cmd = funct[4:1];

   always_comb begin
      alu_control  = 2'b00;
      flag_w       = 2'b00;
      no_write_dec = 1'b0;
      if (alu_op) begin
         case (cmd)
            4'b0100: begin
               alu_control = 2'b00;
               flag_w      = {funct[0], funct[0]};
            end
            4'b0010: begin
               alu_control = 2'b01;
               flag_w      = {funct[0], funct[0]};
            end
            4'b0000: begin
               alu_control = 2'b10;
               flag_w      = {funct[0], 1'b0};
            end
            4'b1100: begin
               alu_control = 2'b11;
               flag_w      = {funct[0], 1'b0};
            end
            4'b1010: begin
               alu_control  = 2'b01;
               flag_w       = {funct[0], funct[0]};
               no_write_dec = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // ALUWB no longer has alu_op, so it relies on the value captured in EXECUTE
   assign no_write_eff = (state == S_ALUWB) ? no_write_q : no_write_dec;
   assign rd_pc        = (rd == 4'd15);

   assign ir_write      = reset & ir_w;
   assign pc_write      = reset & (next_pc | (branch & cond_ex) | (reg_w & cond_ex & rd_pc));
   assign reg_write     = reset & reg_w & cond_ex & ~no_write_eff & ~rd_pc;
   assign mem_write     = reset & mem_w & cond_ex;
   assign flag_write    = flag_w & {2{cond_ex & reset}};
   assign illegal_instr = reset & (state == S_UNKNOWN);
   assign state_dbg     = state;

   assign retire = (state == S_MEMWB) || (state == S_MEMWR) || (state == S_ALUWB) ||
                   (state == S_BRANCH) || (state == S_UNKNOWN);

endmodule

// File: tb/tb_multi_ctrl_fsm.sv
// Bench for multi_ctrl_fsm: instruction-level vector table, directed corner
// sequences and random instruction streams against a plan-based reference model.
module tb_multi_ctrl_fsm;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [5:0]  funct = 6'd0;
   logic [3:0]  rd = 4'd0;
   logic        cond_ex = 1'b0;
   logic        ir_write, adr_src, alu_src_a;
   logic [1:0]  alu_src_b, result_src, alu_control, flag_write;
   logic        pc_write, reg_write, mem_write, illegal_instr;
   logic [3:0]  state_dbg;
   logic [31:0] instret;

   int n_checks = 0;
   int n_pass   = 0;

   multi_ctrl_fsm dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .rd(rd), .cond_ex(cond_ex),
      .ir_write(ir_write), .adr_src(adr_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .result_src(result_src), .alu_control(alu_control),
      .pc_write(pc_write), .reg_write(reg_write), .mem_write(mem_write),
      .flag_write(flag_write), .illegal_instr(illegal_instr),
      .state_dbg(state_dbg), .instret(instret)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   // Per-step controls, bits: ir, next_pc, adr, src_a, src_b[2], res[2], reg_w, mem_w, alu_op, branch
   localparam logic [11:0] CTRL_TAB [0:10] = '{
      12'b110110100000, 12'b000110100000, 12'b000001000000, 12'b001000000000,
      12'b000000011000, 12'b001000000100, 12'b000000000010, 12'b000001000010,
      12'b000000001000, 12'b000001100001, 12'b000000000000
   };

   int          m_state;
   int          m_plan[$];
   logic [31:0] m_ret;
   logic        m_nw;
   bit          m_valid = 1'b0;

   // An instruction is a list of steps chosen once at DECODE; it retires when the list runs out
   always @(posedge clk) begin
      if (!reset) begin
         m_state = 0;
         m_plan.delete();
         m_ret   = 32'd0;
         m_nw    = 1'b0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         if (m_state == 6 || m_state == 7) m_nw = (funct[4:1] == 4'b1010);
         if (m_state == 0) m_state = 1;
         else if (m_state == 1) begin
            m_plan.delete();
            case (op)
               2'b01: begin
                  m_plan.push_back(2);
                  if (funct[0]) begin m_plan.push_back(3); m_plan.push_back(4); end
                  else m_plan.push_back(5);
               end
               2'b00: begin m_plan.push_back(funct[5] ? 7 : 6); m_plan.push_back(8); end
               2'b10: m_plan.push_back(9);
               default: m_plan.push_back(10);
            endcase
            m_state = m_plan.pop_front();
         end else if (m_plan.size() == 0) begin
            m_ret   = m_ret + 32'd1;
            m_state = 0;
         end else m_state = m_plan.pop_front();
      end
   end

   function automatic logic [50:0] model_out();
      logic [11:0] c;
      logic [1:0]  alu, flg, fw;
      logic        nwc, nw_eff, rd15, pcw, rw, mw, ill, irw;
      c = reset ? CTRL_TAB[m_state] : CTRL_TAB[0];
      alu = 2'b00; flg = 2'b00; nwc = 1'b0;
      if (c[1]) begin
         case (funct[4:1])
            4'b0100: begin alu = 2'd0; flg = {2{funct[0]}}; end
            4'b0010: begin alu = 2'd1; flg = {2{funct[0]}}; end
            4'b0000: begin alu = 2'd2; flg = {funct[0], 1'b0}; end
            4'b1100: begin alu = 2'd3; flg = {funct[0], 1'b0}; end
            4'b1010: begin alu = 2'd1; flg = {2{funct[0]}}; nwc = 1'b1; end
            default: ;
         endcase
      end
      nw_eff = (m_state == 8) ? m_nw : nwc;
      rd15 = (rd == 4'd15);
      pcw  = c[10] | (c[0] & cond_ex) | (c[3] & cond_ex & rd15);
      rw   = c[3] & cond_ex & ~nw_eff & ~rd15;
      mw   = c[2] & cond_ex;
      fw   = flg & {2{cond_ex}};
      ill  = (m_state == 10);
      irw  = c[11];
      if (!reset) begin
         pcw = 1'b0; rw = 1'b0; mw = 1'b0; fw = 2'b00; ill = 1'b0; irw = 1'b0;
      end
      return {irw, c[9], c[8], c[7:6], c[5:4], alu, pcw, rw, mw, fw, ill, 4'(m_state), m_ret};
   endfunction

   logic [50:0] dut_vec;
   assign dut_vec = {ir_write, adr_src, alu_src_a, alu_src_b, result_src, alu_control,
                     pc_write, reg_write, mem_write, flag_write, illegal_instr, state_dbg, instret};

   // ---------------- scoreboard: every cycle against the model ----------------
   always @(negedge clk)
      if (m_valid) check($sformatf("cycle_s%0d", m_state), 64'(dut_vec), 64'(model_out()));

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_instr(input logic [1:0] i_op, input logic [5:0] i_funct,
                            input logic [3:0] i_rd, input logic i_cex,
                            output int lat, output int n_rw, output int n_mw,
                            output int n_pw, output int n_ill,
                            output logic [1:0] ex_alu, output logic [1:0] ex_flg);
      op = i_op; funct = i_funct; rd = i_rd; cond_ex = i_cex;
      lat = 0; n_rw = 0; n_mw = 0; n_pw = 0; n_ill = 0;
      ex_alu = 2'bxx; ex_flg = 2'bxx;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         n_rw  += int'(reg_write);
         n_mw  += int'(mem_write);
         n_pw  += int'(pc_write);
         n_ill += int'(illegal_instr);
         if (c == 2) begin ex_alu = alu_control; ex_flg = flag_write; end
         tick();
         lat = c + 1;
         if (state_dbg == 4'd0) break;
      end
   endtask

   typedef struct {
      logic [1:0] op;
      logic [5:0] funct;
      logic [3:0] rd;
      logic       cex;
      int         lat;
      int         n_rw;
      int         n_mw;
      int         n_pw;
      int         n_ill;
      logic [1:0] ex_alu;
      logic [1:0] ex_flg;
   } vec_t;

   vec_t vecs[15];

   initial begin
      int lat, n_rw, n_mw, n_pw, n_ill;
      logic [1:0] ex_alu, ex_flg;
      logic [31:0] exp_ret;
      bit done;

      //             op     funct      rd    cex lat rw mw pw il alu    flg
      vecs[0]  = '{2'b01, 6'b011001, 4'd3,  1'b1, 5, 1, 0, 1, 0, 2'b00, 2'b00}; // LDR
      vecs[1]  = '{2'b01, 6'b011000, 4'd3,  1'b0, 4, 0, 0, 1, 0, 2'b00, 2'b00}; // STR, not taken
      vecs[2]  = '{2'b01, 6'b011000, 4'd3,  1'b1, 4, 0, 1, 1, 0, 2'b00, 2'b00}; // STR
      vecs[3]  = '{2'b00, 6'b101000, 4'd3,  1'b1, 4, 1, 0, 1, 0, 2'b00, 2'b00}; // ADD imm
      vecs[4]  = '{2'b00, 6'b010101, 4'd3,  1'b1, 4, 0, 0, 1, 0, 2'b01, 2'b11}; // CMP reg
      vecs[5]  = '{2'b01, 6'b011001, 4'd4,  1'b1, 5, 1, 0, 1, 0, 2'b00, 2'b00}; // LDR after CMP
      vecs[6]  = '{2'b00, 6'b000101, 4'd2,  1'b1, 4, 1, 0, 1, 0, 2'b01, 2'b11}; // SUBS
      vecs[7]  = '{2'b00, 6'b000001, 4'd2,  1'b1, 4, 1, 0, 1, 0, 2'b10, 2'b10}; // ANDS
      vecs[8]  = '{2'b00, 6'b111000, 4'd5,  1'b0, 4, 0, 0, 1, 0, 2'b11, 2'b00}; // ORR imm, not taken
      vecs[9]  = '{2'b10, 6'b000000, 4'd0,  1'b1, 3, 0, 0, 2, 0, 2'b00, 2'b00}; // B taken
      vecs[10] = '{2'b10, 6'b000000, 4'd0,  1'b0, 3, 0, 0, 1, 0, 2'b00, 2'b00}; // B not taken
      vecs[11] = '{2'b11, 6'b000000, 4'd0,  1'b1, 3, 0, 0, 1, 1, 2'b00, 2'b00}; // illegal
      vecs[12] = '{2'b01, 6'b011001, 4'd15, 1'b1, 5, 0, 0, 2, 0, 2'b00, 2'b00}; // LDR to PC
      vecs[13] = '{2'b00, 6'b001001, 4'd15, 1'b0, 4, 0, 0, 1, 0, 2'b00, 2'b00}; // ADDS to PC, not taken
      vecs[14] = '{2'b00, 6'b001111, 4'd1,  1'b1, 4, 1, 0, 1, 0, 2'b00, 2'b00}; // unsupported cmd

      reset = 1'b0;
      tick();
      tick();
      check("reset_state", 64'(state_dbg), 64'd0);
      check("reset_instret", 64'(instret), 64'd0);
      reset = 1'b1;

      // ---------------- table-driven instructions ----------------
      exp_ret = 32'd0;
      for (int v = 0; v < 15; v++) begin
         run_instr(vecs[v].op, vecs[v].funct, vecs[v].rd, vecs[v].cex,
                   lat, n_rw, n_mw, n_pw, n_ill, ex_alu, ex_flg);
         exp_ret = exp_ret + 32'd1;
         check($sformatf("v%0d_latency", v), 64'(lat), 64'(vecs[v].lat));
         check($sformatf("v%0d_reg_write", v), 64'(n_rw), 64'(vecs[v].n_rw));
         check($sformatf("v%0d_mem_write", v), 64'(n_mw), 64'(vecs[v].n_mw));
         check($sformatf("v%0d_pc_write", v), 64'(n_pw), 64'(vecs[v].n_pw));
         check($sformatf("v%0d_illegal", v), 64'(n_ill), 64'(vecs[v].n_ill));
         check($sformatf("v%0d_alu_control", v), 64'(ex_alu), 64'(vecs[v].ex_alu));
         check($sformatf("v%0d_flag_write", v), 64'(ex_flg), 64'(vecs[v].ex_flg));
         check($sformatf("v%0d_instret", v), 64'(instret), 64'(exp_ret));
      end

      // ---------------- CMP: funct changes under ALUWB, write stays suppressed ----------------
      op = 2'b00; funct = 6'b010101; rd = 4'd3; cond_ex = 1'b1;
      tick(); tick(); tick();
      funct = 6'b101000;
      @(negedge clk);
      check("cmp_latch_state", 64'(state_dbg), 64'd8);
      check("cmp_latch_reg_write", 64'(reg_write), 64'd0);
      tick();
      check("cmp_latch_back_fetch", 64'(state_dbg), 64'd0);

      // ---------------- reset asserted in MEMRD ----------------
      op = 2'b01; funct = 6'b011001; rd = 4'd15; cond_ex = 1'b1;
      tick(); tick(); tick();
      check("rst_pre_state", 64'(state_dbg), 64'd3);
      reset = 1'b0;
      @(negedge clk);
      check("rst_low_writes", 64'({ir_write, pc_write, reg_write, mem_write, flag_write, illegal_instr}), 64'd0);
      check("rst_low_fetch_decode", 64'({adr_src, alu_src_a, alu_src_b, result_src}), 64'b0_1_10_10);
      tick();
      check("rst_state", 64'(state_dbg), 64'd0);
      check("rst_instret", 64'(instret), 64'd0);
      @(negedge clk);
      check("rst_hold_writes", 64'({ir_write, pc_write, reg_write, mem_write, flag_write, illegal_instr}), 64'd0);
      tick();
      reset = 1'b1;
      run_instr(2'b11, 6'b000000, 4'd0, 1'b1, lat, n_rw, n_mw, n_pw, n_ill, ex_alu, ex_flg);
      check("post_rst_illegal_pulse", 64'(n_ill), 64'd1);
      check("post_rst_instret", 64'(instret), 64'd1);

      // ---------------- random instruction stream ----------------
      for (int i = 0; i < 300; i++) begin
         op    = 2'($urandom_range(3, 0));
         funct = 6'($urandom_range(63, 0));
         rd    = ($urandom_range(3, 0) == 0) ? 4'd15 : 4'($urandom_range(15, 0));
         done  = 1'b0;
         for (int c = 0; c < 12; c++) begin
            cond_ex = 1'($urandom_range(1, 0));
            reset   = ($urandom_range(59, 0) != 0);
            tick();
            reset = 1'b1;
            if (state_dbg == 4'd0) begin done = 1'b1; break; end
         end
         if (!done) check($sformatf("rand%0d_return_to_fetch", i), 64'(state_dbg), 64'd0);
      end

      tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
